// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - load/store memory responder with programmable wait states
// Single request in flight; RV32I sub-word access on an internal word array.
module data_mem_responder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  resp_err_o
);

  localparam int IW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic                  r_we;
  logic [2:0]            r_funct3;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_ready;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

  // With zero wait states the access happens on the accept edge, so use the live inputs.
  logic                  w_in_idle;
  logic                  w_we;
  logic [2:0]            w_funct3;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [1:0]            w_lane;
  logic [IW-1:0]         w_idx;
  logic                  w_range_err;
  logic                  w_f3_err;
  logic                  w_align_err;
  logic                  w_err;
  logic [3:0]            w_be;
  logic [DATA_WIDTH-1:0] w_wrep;
  logic [DATA_WIDTH-1:0] w_word;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_WIDTH-1:0] w_load;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_accept;
  logic                  w_fire;
  logic                  w_mem_wr;

  assign w_in_idle   = (r_state == S_IDLE);
  assign w_we        = w_in_idle ? req_we_i     : r_we;
  assign w_funct3    = w_in_idle ? req_funct3_i : r_funct3;
  assign w_addr      = w_in_idle ? req_addr_i   : r_addr;
  assign w_wdata     = w_in_idle ? req_wdata_i  : r_wdata;
  assign w_lane      = w_addr[1:0];
  assign w_idx       = w_addr[IW+1:2];
  assign w_range_err = (w_addr[ADDR_WIDTH-1:2] >= (ADDR_WIDTH-2)'(DEPTH_WORDS));

  always_comb begin
    w_f3_err    = 1'b0;
    w_align_err = 1'b0;
    case (w_funct3)
      3'b000: w_align_err = 1'b0;
      3'b001: w_align_err = w_lane[0];
      3'b010: w_align_err = |w_lane;
      3'b100: w_f3_err    = w_we;
      3'b101: begin
        w_f3_err    = w_we;
        w_align_err = w_lane[0];
      end
      default: w_f3_err = 1'b1;
    endcase
  end

  assign w_err = w_f3_err | w_align_err | w_range_err;

  always_comb begin
    w_be   = 4'b1111;
    w_wrep = w_wdata;
    case (w_funct3[1:0])
      2'b00: begin
        w_be   = 4'b0001 << w_lane;
        w_wrep = {4{w_wdata[7:0]}};
      end
      2'b01: begin
        w_be   = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wrep = {2{w_wdata[15:0]}};
      end
      default: begin
        w_be   = 4'b1111;
        w_wrep = w_wdata;
      end
    endcase
  end

  assign w_word = r_mem[w_idx];
  assign w_byte = w_word[{w_lane, 3'b000} +: 8];
  assign w_half = w_lane[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    case (w_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'b0, w_byte};
      3'b101:  w_load = {16'b0, w_half};
      default: w_load = w_word;
    endcase
  end

  assign w_rdata  = (w_we || w_err) ? '0 : w_load;
  assign w_accept = w_in_idle && req_valid_i;
  assign w_fire   = (w_accept && (WAIT_CYCLES == 0)) || ((r_state == S_WAIT) && (r_cnt == 4'd0));
  assign w_mem_wr = !rst && w_fire && w_we && !w_err;

  // Array is deliberately outside the reset domain; contents survive rst.
  always_ff @(posedge clk) begin
    if (w_mem_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wrep[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_ready  <= 1'b1;
      r_valid  <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      r_we     <= 1'b0;
      r_funct3 <= 3'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid_i) begin
            r_we     <= req_we_i;
            r_funct3 <= req_funct3_i;
            r_addr   <= req_addr_i;
            r_wdata  <= req_wdata_i;
            r_ready  <= 1'b0;
            if (WAIT_CYCLES > 0) begin
              r_state <= S_WAIT;
              r_cnt   <= 4'(WAIT_CYCLES - 1);
            end else begin
              r_state <= S_RESP;
              r_valid <= 1'b1;
              r_rdata <= w_rdata;
              r_err   <= w_err;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_RESP;
            r_valid <= 1'b1;
            r_rdata <= w_rdata;
            r_err   <= w_err;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (resp_ready_i) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o  = r_ready;
  assign resp_valid_o = r_valid;
  assign resp_rdata_o = r_rdata;
  assign resp_err_o   = r_err;

endmodule
